// File: rtl/signed_accum_8.sv
// signed_accum_8: sums blocks of BLOCK_LEN two's-complement samples into an ACC_W-bit total,
// valid/ready handshake on both sides. Optional clamping: define SIGNED_ACCUM_SATURATE_EN.
module signed_accum_8 #(
  parameter int N         = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     res_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             sat_flag,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] add_res;
  logic             add_sat;

  assign sample_ext = {{(ACC_W - N){res_signed[N-1]}}, res_signed};

`ifdef SIGNED_ACCUM_SATURATE_EN
  // One guard bit: overflow iff the two top bits of the widened sum disagree.
  logic [ACC_W:0] sum_wide;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {sample_ext[ACC_W-1], sample_ext};
    add_sat  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    if (!add_sat) begin
      add_res = sum_wide[ACC_W-1:0];
    end else if (sum_wide[ACC_W]) begin
      add_res = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      add_res = {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end
`else
  assign add_res = acc_q + sample_ext;
  assign add_sat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = sample_ext;
            count_d = 8'd1;
            state_d = (BLOCK_LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d   = add_res;
            count_d = count_q + 8'd1;
            sat_d   = sat_q | add_sat;
            if (count_q == LAST_CNT) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign sat_flag  = sat_q;
  assign count     = count_q;

endmodule

// File: tb/tb_signed_accum_8.sv
// Bench for signed_accum_8: default instance (N=8, ACC_W=16, BLOCK_LEN=4) plus an
// ACC_W=10, BLOCK_LEN=8 instance whose expectations follow SIGNED_ACCUM_SATURATE_EN.
module tb_signed_accum_8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_clr, a_iv, a_or;
  logic [7:0] a_res;
  logic       a_ir, a_ov, a_sat;
  logic [15:0] a_sum;
  logic [7:0] a_cnt;

  logic       b_clr, b_iv, b_or;
  logic [7:0] b_res;
  logic       b_ir, b_ov, b_sat;
  logic [9:0] b_sum;
  logic [7:0] b_cnt;

  signed_accum_8 u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_iv), .in_ready(a_ir),
    .res_signed(a_res), .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum),
    .sat_flag(a_sat), .count(a_cnt)
  );

  signed_accum_8 #(.N(8), .ACC_W(10), .BLOCK_LEN(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_iv), .in_ready(b_ir),
    .res_signed(b_res), .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum),
    .sat_flag(b_sat), .count(b_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] sum;
    logic        sat;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  typedef struct {
    logic [7:0]  s [4];
    logic [15:0] sum;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] s [4], input logic [15:0] exp_sum);
    logic [15:0] part;
    part = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a_iv  = 1'b1;
      a_res = s[i];
      part  = part + {{8{s[i][7]}}, s[i]};
      if (i == 3) sb_a.push_back('{sum: exp_sum, sat: 1'b0, cnt: 8'd4});
      tick();
      if (i < 3) begin
        check("a_partial_sum", 32'(a_sum), 32'(part));
        check("a_partial_cnt", 32'(a_cnt), 32'(i + 1));
        check("a_early_valid", 32'(a_ov), 32'd0);
      end
    end
    a_iv  = 1'b0;
    a_res = '0;
  endtask

  task automatic pop_a(input string tag);
    exp_t e;
    check({tag, "_valid"}, 32'(a_ov), 32'd1);
    if (sb_a.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got empty scoreboard expected one entry", tag);
    end else begin
      e = sb_a.pop_front();
      check({tag, "_sum"}, 32'(a_sum), 32'(e.sum));
      check({tag, "_cnt"}, 32'(a_cnt), 32'(e.cnt));
      check({tag, "_sat"}, 32'(a_sat), 32'(e.sat));
      check({tag, "_in_ready"}, 32'(a_ir), 32'd0);
    end
  endtask

  task automatic consume_a(input string tag);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    check({tag, "_idle_ready"}, 32'(a_ir), 32'd1);
    check({tag, "_idle_valid"}, 32'(a_ov), 32'd0);
    check({tag, "_idle_sum"}, 32'(a_sum), 32'd0);
    check({tag, "_idle_cnt"}, 32'(a_cnt), 32'd0);
  endtask

  task automatic run_b(input string tag, input logic [7:0] val, input logic [9:0] exp_sum,
                       input logic exp_sat);
    exp_t e;
    for (int unsigned i = 0; i < 8; i++) begin
      b_iv  = 1'b1;
      b_res = val;
      if (i == 7) sb_b.push_back('{sum: 16'(exp_sum), sat: exp_sat, cnt: 8'd8});
      tick();
      if (i == 6) check({tag, "_early_valid"}, 32'(b_ov), 32'd0);
    end
    b_iv  = 1'b0;
    b_res = '0;
    check({tag, "_valid"}, 32'(b_ov), 32'd1);
    if (sb_b.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got empty scoreboard expected one entry", tag);
    end else begin
      e = sb_b.pop_front();
      for (int unsigned h = 0; h < 2; h++) begin
        check({tag, "_sum"}, 32'(b_sum), 32'(e.sum));
        check({tag, "_sat"}, 32'(b_sat), 32'(e.sat));
        check({tag, "_cnt"}, 32'(b_cnt), 32'(e.cnt));
        tick();
      end
    end
    b_or = 1'b1;
    tick();
    b_or = 1'b0;
    check({tag, "_cleared_sat"}, 32'(b_sat), 32'd0);
    check({tag, "_cleared_sum"}, 32'(b_sum), 32'd0);
    check({tag, "_cleared_valid"}, 32'(b_ov), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] blk [4];

    vecs[0] = '{s: '{8'hF2, 8'hE7, 8'h0D, 8'h19}, sum: 16'hFFFF};
    vecs[1] = '{s: '{8'h01, 8'h02, 8'h03, 8'h04}, sum: 16'h000A};
    vecs[2] = '{s: '{8'h80, 8'h80, 8'h80, 8'h80}, sum: 16'hFE00};
    vecs[3] = '{s: '{8'h7F, 8'h80, 8'h01, 8'hFF}, sum: 16'hFFFF};
    vecs[4] = '{s: '{8'h00, 8'h00, 8'h00, 8'h00}, sum: 16'h0000};
    vecs[5] = '{s: '{8'h7F, 8'h7F, 8'h7F, 8'h7F}, sum: 16'h01FC};
    vecs[6] = '{s: '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, sum: 16'hFFFC};

    rst_n = 1'b0;
    a_clr = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_res = '0;
    b_clr = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_res = '0;
    tick();
    tick();
    check("rst_sum", 32'(a_sum), 32'h0000);
    check("rst_valid", 32'(a_ov), 32'd0);
    check("rst_ready", 32'(a_ir), 32'd1);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    check("rst_sat", 32'(a_sat), 32'd0);
    check("rst_b_sum", 32'(b_sum), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int unsigned v = 0; v < 7; v++) begin
      send_a(vecs[v].s, vecs[v].sum);
      pop_a($sformatf("vec%0d", v));
      consume_a($sformatf("vec%0d", v));
    end

    // Backpressure: DONE holds under out_ready=0, ignores in_valid, consume accepts nothing.
    blk = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    send_a(blk, 16'h01FC);
    pop_a("bp");
    a_iv  = 1'b1;
    a_res = 8'h55;
    for (int unsigned c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 32'(a_ov), 32'd1);
      check("bp_hold_sum", 32'(a_sum), 32'h01FC);
      check("bp_hold_cnt", 32'(a_cnt), 32'd4);
    end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    check("bp_rel_ready", 32'(a_ir), 32'd1);
    check("bp_rel_sum", 32'(a_sum), 32'd0);
    check("bp_rel_cnt", 32'(a_cnt), 32'd0);
    tick();
    check("bp_next_cnt", 32'(a_cnt), 32'd1);
    check("bp_next_sum", 32'(a_sum), 32'h0055);
    a_iv  = 1'b0;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("bp_clr_cnt", 32'(a_cnt), 32'd0);

    // clr mid-block with a sample presented alongside.
    a_iv = 1'b1; a_res = 8'h10; tick();
    a_res = 8'h20; tick();
    check("clr_pre_sum", 32'(a_sum), 32'h0030);
    check("clr_pre_cnt", 32'(a_cnt), 32'd2);
    a_clr = 1'b1; a_res = 8'h30; tick();
    a_clr = 1'b0; a_iv = 1'b0; a_res = '0;
    check("clr_sum", 32'(a_sum), 32'd0);
    check("clr_cnt", 32'(a_cnt), 32'd0);
    check("clr_ready", 32'(a_ir), 32'd1);
    tick();
    check("clr_discard_sum", 32'(a_sum), 32'd0);
    blk = '{8'h01, 8'h01, 8'h01, 8'h01};
    send_a(blk, 16'h0004);
    pop_a("clr_next");
    consume_a("clr_next");

    // clr beats a held result in DONE.
    blk = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_a(blk, 16'h000A);
    pop_a("clr_done");
    a_clr = 1'b1; a_or = 1'b1; a_iv = 1'b1; a_res = 8'h09;
    tick();
    a_clr = 1'b0; a_or = 1'b0; a_iv = 1'b0;
    check("clr_done_valid", 32'(a_ov), 32'd0);
    check("clr_done_sum", 32'(a_sum), 32'd0);
    check("clr_done_cnt", 32'(a_cnt), 32'd0);

    // Asynchronous reset mid-block, away from any clock edge.
    a_iv = 1'b1; a_res = 8'h11; tick();
    a_res = 8'h22; tick();
    a_iv = 1'b0;
    check("rmb_pre_cnt", 32'(a_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rmb_sum", 32'(a_sum), 32'd0);
    check("rmb_cnt", 32'(a_cnt), 32'd0);
    check("rmb_ready", 32'(a_ir), 32'd1);
    check("rmb_valid", 32'(a_ov), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("rmb_no_valid", 32'(a_ov), 32'd0);
    end
    blk = '{8'h05, 8'hFB, 8'h40, 8'h40};
    send_a(blk, 16'h0080);
    pop_a("rmb_resume");
    consume_a("rmb_resume");

`ifdef SIGNED_ACCUM_SATURATE_EN
    run_b("b_pos", 8'h7F, 10'h1FF, 1'b1);
    run_b("b_neg", 8'h80, 10'h200, 1'b1);
`else
    run_b("b_pos", 8'h7F, 10'h3F8, 1'b0);
    run_b("b_neg", 8'h80, 10'h000, 1'b0);
`endif
    run_b("b_small", 8'h03, 10'h018, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
